// File: rtl/food_spawner.sv
// Turns the LFSR stream into a free food tile: rejection-sampled X/Y, occupancy check with retry,
// and a raster-scan fallback once random tries are exhausted.
module food_spawner #(
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int XW        = 6,
  parameter int YW        = 5,
  parameter int MAX_TRIES = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          spawn_req,
  input  logic [8:0]    rnd,
  input  logic          rnd_valid,
  output logic          occ_rd,
  output logic [XW-1:0] occ_x,
  output logic [YW-1:0] occ_y,
  input  logic          occ_hit,
  output logic [XW-1:0] food_x,
  output logic [YW-1:0] food_y,
  output logic          food_valid,
  output logic          busy,
  output logic          board_full
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int SW    = $clog2(CELLS + 1);
  localparam int TW    = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    IDLE, SAMPLE_X, SAMPLE_Y, CHECK, WAIT, SCAN_ADV, DONE
  } state_t;

  state_t        state;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [TW-1:0] tries;
  logic [SW-1:0] scan_cnt;
  logic          scan_mode;

  logic [TW-1:0] tries_nx;
  logic [SW-1:0] scan_nx;
  logic          x_ok, y_ok;
  logic          unused_rnd;

  // One extra bit so a grid that fills the whole coordinate space still compares correctly
  assign x_ok     = {1'b0, rnd[XW-1:0]} < (XW+1)'(GRID_W);
  assign y_ok     = {1'b0, rnd[YW-1:0]} < (YW+1)'(GRID_H);
  assign tries_nx = tries + TW'(1);
  assign scan_nx  = scan_cnt + SW'(1);
  assign unused_rnd = ^rnd;

  assign occ_rd = (state == CHECK);
  assign occ_x  = cx;
  assign occ_y  = cy;
  assign busy   = (state != IDLE) && (state != DONE);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      cx         <= '0;
      cy         <= '0;
      tries      <= '0;
      scan_cnt   <= '0;
      scan_mode  <= 1'b0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      board_full <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (spawn_req) begin
          food_valid <= 1'b0;
          board_full <= 1'b0;
          tries      <= '0;
          scan_mode  <= 1'b0;
          state      <= SAMPLE_X;
        end
        SAMPLE_X: if (rnd_valid && x_ok) begin
          cx    <= rnd[XW-1:0];
          state <= SAMPLE_Y;
        end
        SAMPLE_Y: if (rnd_valid && y_ok) begin
          cy    <= rnd[YW-1:0];
          state <= CHECK;
        end
        CHECK: state <= WAIT;
        WAIT: begin
          if (!occ_hit) begin
            food_x     <= cx;
            food_y     <= cy;
            food_valid <= 1'b1;
            state      <= DONE;
          end else if (!scan_mode) begin
            tries <= tries_nx;
            if (tries_nx == TW'(MAX_TRIES)) begin
              scan_mode <= 1'b1;
              scan_cnt  <= '0;
              state     <= SCAN_ADV;
            end else begin
              state <= SAMPLE_X;
            end
          end else begin
            // Scan starts just past the last random candidate, so CELLS hits means every tile
            scan_cnt <= scan_nx;
            if (scan_nx == SW'(CELLS)) begin
              board_full <= 1'b1;
              food_valid <= 1'b0;
              state      <= DONE;
            end else begin
              state <= SCAN_ADV;
            end
          end
        end
        SCAN_ADV: begin
          if (cx == XW'(GRID_W - 1)) begin
            cx <= '0;
            cy <= (cy == YW'(GRID_H - 1)) ? '0 : cy + YW'(1);
          end else begin
            cx <= cx + XW'(1);
          end
          state <= CHECK;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner: hand-timed rnd streams and a simple occupancy model.
module tb_food_spawner;

  logic       Clk = 1'b0;
  logic       Reset, spawn_req, rnd_valid, occ_hit;
  logic [8:0] rnd;
  logic       occ_rd, food_valid, busy, board_full;
  logic [5:0] occ_x, food_x;
  logic [4:0] occ_y, food_y;

  food_spawner dut (
    .Clk(Clk), .Reset(Reset), .spawn_req(spawn_req), .rnd(rnd), .rnd_valid(rnd_valid),
    .occ_rd(occ_rd), .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .busy(busy),
    .board_full(board_full)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Occupancy model: 0 empty, 1 all but (0,0), 2 full, 3 only (10,7)
  int   occ_mode = 0;
  logic pend_hit = 1'b0;

  function automatic logic occupied(input logic [5:0] x, input logic [4:0] y);
    case (occ_mode)
      0:       return 1'b0;
      1:       return !(x == 6'd0 && y == 5'd0);
      2:       return 1'b1;
      default: return (x == 6'd10 && y == 5'd7);
    endcase
  endfunction

  // occ_hit answers the lookup seen one cycle earlier
  always @(negedge Clk) begin
    occ_hit  = pend_hit;
    pend_hit = occ_rd ? occupied(occ_x, occ_y) : 1'b0;
  end

  logic [9:0] sq[$];
  logic [8:0] hold_rnd = 9'h0;
  logic       hold_v   = 1'b0;
  int         rd_lat, rd_x, rd_y;

  // lat counts edges after the one that samples spawn_req
  task automatic run_spawn(input int maxcyc, input int inj,
                           output int lat, output int nrd, output logic fv_clr);
    @(negedge Clk) spawn_req = 1'b1;
    @(negedge Clk) spawn_req = 1'b0;
    lat = 0; nrd = 0; rd_lat = -1; rd_x = -1; rd_y = -1;
    fv_clr = !food_valid && !board_full;
    do begin
      if (sq.size() > 0) {rnd_valid, rnd} = sq.pop_front();
      else begin rnd_valid = hold_v; rnd = hold_rnd; end
      spawn_req = (lat == inj);
      @(negedge Clk);
      lat++;
      if (occ_rd) begin
        if (nrd == 0) begin rd_lat = lat; rd_x = occ_x; rd_y = occ_y; end
        nrd++;
      end
    end while (busy && lat < maxcyc);
    spawn_req = 1'b0;
    rnd_valid = 1'b0;
    if (busy) chk("timeout_busy", 32'(busy), 0);
  endtask

  int   lat, nrd;
  logic fvc;

  initial begin
    Reset = 1'b0; spawn_req = 1'b0; rnd = '0; rnd_valid = 1'b0; occ_hit = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      spawn_req = 1'($urandom); rnd = 9'($urandom); rnd_valid = 1'($urandom);
    end
    @(negedge Clk);
    chk("rst_food_valid", 32'(food_valid), 0);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_occ_rd",     32'(occ_rd), 0);
    chk("rst_board_full", 32'(board_full), 0);
    chk("rst_food_xy",    32'({food_x, food_y}), 0);
    chk("rst_occ_xy",     32'({occ_x, occ_y}), 0);
    spawn_req = 1'b0; rnd_valid = 1'b0;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // Basic spawn, no rejects, free tile
    occ_mode = 0;
    sq.push_back({1'b1, 9'h00A}); sq.push_back({1'b1, 9'h007});
    run_spawn(50, -1, lat, nrd, fvc);
    chk("basic_lat",    32'(lat), 4);
    chk("basic_rd_lat", 32'(rd_lat), 2);
    chk("basic_rd_xy",  32'(rd_x * 100 + rd_y), 1007);
    chk("basic_nrd",    32'(nrd), 1);
    chk("basic_food_x", 32'(food_x), 10);
    chk("basic_food_y", 32'(food_y), 7);
    chk("basic_fv",     32'(food_valid), 1);
    chk("basic_full",   32'(board_full), 0);

    // Range rejects on both axes
    sq.push_back({1'b1, 9'h03F}); sq.push_back({1'b1, 9'h005});
    sq.push_back({1'b1, 9'h01F}); sq.push_back({1'b1, 9'h003});
    run_spawn(50, -1, lat, nrd, fvc);
    chk("rej_fv_cleared", 32'(fvc), 1);
    chk("rej_lat",    32'(lat), 6);
    chk("rej_food_x", 32'(food_x), 5);
    chk("rej_food_y", 32'(food_y), 3);
    chk("rej_nrd",    32'(nrd), 1);

    // First candidate collides, second is free
    occ_mode = 3;
    sq.push_back({1'b1, 9'h00A}); sq.push_back({1'b1, 9'h007});
    sq.push_back({1'b0, 9'h000}); sq.push_back({1'b0, 9'h000});
    sq.push_back({1'b1, 9'h002}); sq.push_back({1'b1, 9'h002});
    run_spawn(50, -1, lat, nrd, fvc);
    chk("retry_nrd",    32'(nrd), 2);
    chk("retry_lat",    32'(lat), 8);
    chk("retry_food",   32'({food_x, food_y}), 32'({6'd2, 5'd2}));
    chk("retry_fv",     32'(food_valid), 1);
    chk("retry_full",   32'(board_full), 0);

    // spawn_req during SAMPLE_Y must be ignored
    occ_mode = 0;
    sq.push_back({1'b1, 9'h003}); sq.push_back({1'b1, 9'h004});
    run_spawn(50, 1, lat, nrd, fvc);
    chk("busyreq_lat", 32'(lat), 4);
    chk("busyreq_nrd", 32'(nrd), 1);
    repeat (5) @(negedge Clk);
    chk("busyreq_idle", 32'(busy), 0);
    chk("busyreq_food", 32'({food_valid, food_x, food_y}), 32'({1'b1, 6'd3, 5'd4}));

    // Every tile but (0,0) occupied: 8 misses at (5,5), then scan wraps to (0,0)
    occ_mode = 1; hold_v = 1'b1; hold_rnd = 9'h005;
    run_spawn(6000, -1, lat, nrd, fvc);
    chk("scan_lat",  32'(lat), 3017);
    chk("scan_nrd",  32'(nrd), 1003);
    chk("scan_food", 32'({food_x, food_y}), 0);
    chk("scan_fv",   32'(food_valid), 1);
    chk("scan_full", 32'(board_full), 0);

    // Fully occupied board
    occ_mode = 2;
    run_spawn(6000, -1, lat, nrd, fvc);
    chk("full_lat",  32'(lat), 3632);
    chk("full_nrd",  32'(nrd), 1208);
    chk("full_flag", 32'(board_full), 1);
    chk("full_fv",   32'(food_valid), 0);
    chk("full_busy", 32'(busy), 0);
    hold_v = 1'b0;

    // Reset while waiting on the occupancy answer
    occ_mode = 0;
    @(negedge Clk) spawn_req = 1'b1;
    @(negedge Clk) begin spawn_req = 1'b0; rnd = 9'h00A; rnd_valid = 1'b1; end
    @(negedge Clk) rnd = 9'h007;
    @(negedge Clk) rnd_valid = 1'b0;
    chk("rstw_check_rd", 32'(occ_rd), 1);
    chk("rstw_full_clr", 32'(board_full), 0);
    @(negedge Clk) Reset = 1'b0;
    @(negedge Clk);
    chk("rstw_occ_rd", 32'(occ_rd), 0);
    chk("rstw_busy",   32'(busy), 0);
    chk("rstw_fv",     32'(food_valid), 0);
    chk("rstw_occ_x",  32'(occ_x), 0);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
